key_conditioner: RTL and testbench



---
 rtl/key_cond_pkg.sv | 14 +
 rtl/key_channel.sv | 105 ++++++++++
 rtl/key_conditioner.sv | 39 +++
 tb/tb_key_conditioner.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/key_cond_pkg.sv
// Shared types and helpers for the push-button conditioner.
package key_cond_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        HELD,
        REPEATING
    } key_state_t;

    function automatic int counter_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/key_channel.sv
// One button channel: synchroniser, debounce counter, press/release FSM and
// auto-repeat counter. All outputs are registered.
module key_channel
    import key_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_PERIOD   = 4,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    input  logic repeat_en,
    output logic level,
    output logic press,
    output logic release_pulse
);

    localparam int CW          = counter_width(DEBOUNCE_CYCLES - 1);
    localparam int RMAX_COUNT  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW          = counter_width(RMAX_COUNT);
    localparam logic [CW-1:0] CNT_LAST    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
    localparam logic [RW-1:0] RCNT_MAX    = RW'(RMAX_COUNT);
    localparam logic          RAW_IDLE    = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic [RW-1:0]          rcnt;
    logic                   rfirst;
    key_state_t             state;
    logic                   pressed_s;
    logic                   accept;

    // Polarity is folded in after the synchroniser so 1 always means pressed.
    assign pressed_s = sync[SYNC_STAGES-1] ^ RAW_IDLE;
    assign accept    = (pressed_s != level) && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync          <= {SYNC_STAGES{RAW_IDLE}};
            cnt           <= '0;
            rcnt          <= '0;
            rfirst        <= 1'b1;
            level         <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            state         <= RELEASED;
        end else begin
            sync          <= {sync[SYNC_STAGES-2:0], key_raw};
            press         <= 1'b0;
            release_pulse <= 1'b0;

            if (pressed_s == level) begin
                cnt <= '0;
            end else if (accept) begin
                cnt   <= '0;
                level <= pressed_s;
            end else begin
                cnt <= cnt + 1'b1;
            end

            // An accepted release always takes priority over a repeat pulse.
            case (state)
                RELEASED: begin
                    if (accept) begin
                        press  <= 1'b1;
                        rcnt   <= '0;
                        rfirst <= 1'b1;
                        state  <= repeat_en ? REPEATING : HELD;
                    end
                end
                HELD: begin
                    if (accept) begin
                        release_pulse <= 1'b1;
                        state         <= RELEASED;
                    end else if (repeat_en) begin
                        rcnt   <= '0;
                        rfirst <= 1'b1;
                        state  <= REPEATING;
                    end
                end
                REPEATING: begin
                    if (accept) begin
                        release_pulse <= 1'b1;
                        state         <= RELEASED;
                    end else if (!repeat_en) begin
                        state <= HELD;
                    end else if (rcnt == (rfirst ? DELAY_LAST : PERIOD_LAST)) begin
                        press  <= 1'b1;
                        rcnt   <= '0;
                        rfirst <= 1'b0;
                    end else if (rcnt != RCNT_MAX) begin
                        rcnt <= rcnt + 1'b1;
                    end
                end
                default: state <= RELEASED;
            endcase
        end
    end

endmodule

// File: rtl/key_conditioner.sv
// Multi-channel push-button front end: one independent key_channel per input.
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int N_KEYS          = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_PERIOD   = 4,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] keys_raw,
    input  logic [N_KEYS-1:0] repeat_en,
    output logic [N_KEYS-1:0] level,
    output logic [N_KEYS-1:0] press,
    output logic [N_KEYS-1:0] release_pulse
);

    for (genvar k = 0; k < N_KEYS; k++) begin : g_chan
        key_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD),
            .ACTIVE_LOW     (ACTIVE_LOW)
        ) u_chan (
            .clk          (clk),
            .reset        (reset),
            .key_raw      (keys_raw[k]),
            .repeat_en    (repeat_en[k]),
            .level        (level[k]),
            .press        (press[k]),
            .release_pulse(release_pulse[k])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed and random stimulus for key_conditioner, checked every cycle
// against a window-based behavioural model of debounce and auto-repeat.
module tb_key_conditioner;

    localparam int NK   = 4;
    localparam int SYNC = 2;
    localparam int DB   = 4;
    localparam int RD   = 8;
    localparam int RP   = 4;
    localparam logic [NK-1:0] IDLE = 4'b1111;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NK-1:0] keys_raw = IDLE;
    logic [NK-1:0] repeat_en = '0;
    logic [NK-1:0] level;
    logic [NK-1:0] press;
    logic [NK-1:0] release_pulse;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state: raw pressed history since reset, held level and repeat timing.
    bit            hist [NK][8192];
    int            ecount = 0;
    bit            m_level [NK];
    bit            m_rep [NK];
    int            m_since [NK];
    logic [NK-1:0] exp_level = '0;
    logic [NK-1:0] exp_press = '0;
    logic [NK-1:0] exp_rel   = '0;

    key_conditioner #(
        .N_KEYS         (NK),
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .ACTIVE_LOW     (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .keys_raw     (keys_raw),
        .repeat_en    (repeat_en),
        .level        (level),
        .press        (press),
        .release_pulse(release_pulse)
    );

    always #5 clk = ~clk;

    // A level change is accepted once the last DB synchronised samples all disagree with it.
    task automatic modelEdge();
        bit flip;
        bit v;
        if (reset) begin
            ecount = 0;
            for (int i = 0; i < NK; i++) begin
                m_level[i] = 1'b0;
                m_rep[i]   = 1'b0;
                m_since[i] = 0;
            end
            exp_level = '0;
            exp_press = '0;
            exp_rel   = '0;
        end else begin
            ecount++;
            for (int i = 0; i < NK; i++) begin
                hist[i][ecount] = !keys_raw[i];
                exp_press[i] = 1'b0;
                exp_rel[i]   = 1'b0;
                flip = 1'b1;
                for (int j = ecount - SYNC - DB + 1; j <= ecount - SYNC; j++) begin
                    v = (j >= 1) ? hist[i][j] : 1'b0;
                    if (v == m_level[i]) flip = 1'b0;
                end
                if (flip) begin
                    m_level[i] = !m_level[i];
                    if (m_level[i]) begin
                        exp_press[i] = 1'b1;
                        m_rep[i]     = repeat_en[i];
                        m_since[i]   = 0;
                    end else begin
                        exp_rel[i] = 1'b1;
                        m_rep[i]   = 1'b0;
                    end
                end else if (m_level[i]) begin
                    if (!repeat_en[i]) begin
                        m_rep[i] = 1'b0;
                    end else if (!m_rep[i]) begin
                        m_rep[i]   = 1'b1;
                        m_since[i] = 0;
                    end else begin
                        m_since[i]++;
                        if (m_since[i] >= RD && ((m_since[i] - RD) % RP) == 0)
                            exp_press[i] = 1'b1;
                    end
                end
                exp_level[i] = m_level[i];
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [NK-1:0] obs, input logic [NK-1:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %b expected %b (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput("level", level, exp_level);
        checkOutput("press", press, exp_press);
        checkOutput("release", release_pulse, exp_rel);
        checkOutput("press_and_release", press & release_pulse, '0);
    endtask

    task automatic applyStimulus(input logic [NK-1:0] raw, input logic [NK-1:0] ren,
                                 input logic rst, input int cycles);
        keys_raw  = raw;
        repeat_en = ren;
        reset     = rst;
        for (int c = 0; c < cycles; c++) stepCycle();
    endtask

    initial begin
        $display("[TB] key_conditioner bench start");

        applyStimulus(IDLE, '0, 1'b1, 3);
        checkOutput("reset_level", level, 4'b0000);
        checkOutput("reset_press", press, 4'b0000);
        applyStimulus(IDLE, '0, 1'b0, 10);

        // Clean press on key 0, no repeat.
        applyStimulus(4'b1110, '0, 1'b0, 6);
        checkOutput("clean_press", press, 4'b0001);
        applyStimulus(4'b1110, '0, 1'b0, 14);
        applyStimulus(IDLE, '0, 1'b0, 6);
        checkOutput("clean_release", release_pulse, 4'b0001);
        checkOutput("clean_level_low", level, 4'b0000);
        applyStimulus(IDLE, '0, 1'b0, 6);

        // Bounce on key 1: 1, 2 and 3 cycle glitches, then a stable press.
        applyStimulus(4'b1101, '0, 1'b0, 1);
        applyStimulus(IDLE,    '0, 1'b0, 1);
        applyStimulus(4'b1101, '0, 1'b0, 2);
        applyStimulus(IDLE,    '0, 1'b0, 1);
        applyStimulus(4'b1101, '0, 1'b0, 3);
        applyStimulus(IDLE,    '0, 1'b0, 8);
        checkOutput("bounce_level", level, 4'b0000);
        applyStimulus(4'b1101, '0, 1'b0, 10);
        applyStimulus(IDLE,    '0, 1'b0, 10);

        // Auto-repeat on key 2.
        applyStimulus(4'b1011, 4'b0100, 1'b0, 6);
        checkOutput("repeat_initial", press, 4'b0100);
        applyStimulus(4'b1011, 4'b0100, 1'b0, 8);
        checkOutput("repeat_first", press, 4'b0100);
        applyStimulus(4'b1011, 4'b0100, 1'b0, 16);
        applyStimulus(IDLE,    4'b0100, 1'b0, 10);

        // Repeat disabled mid-hold.
        applyStimulus(4'b1011, 4'b0100, 1'b0, 19);
        applyStimulus(4'b1011, 4'b0000, 1'b0, 11);
        applyStimulus(IDLE,    4'b0000, 1'b0, 10);

        // Simultaneous press on keys 0 and 3, then release of key 3 only.
        applyStimulus(4'b0110, '0, 1'b0, 6);
        checkOutput("simul_press", press, 4'b1001);
        applyStimulus(4'b0110, '0, 1'b0, 1);
        checkOutput("simul_press_one_cycle", press, 4'b0000);
        applyStimulus(4'b1110, '0, 1'b0, 6);
        checkOutput("simul_release", release_pulse, 4'b1000);
        applyStimulus(IDLE, '0, 1'b0, 8);

        // Reset while key 1 is held.
        applyStimulus(4'b1101, '0, 1'b0, 10);
        checkOutput("hold_level", level, 4'b0010);
        applyStimulus(4'b1101, '0, 1'b1, 2);
        checkOutput("midreset_level", level, 4'b0000);
        checkOutput("midreset_release", release_pulse, 4'b0000);
        applyStimulus(4'b1101, '0, 1'b0, 6);
        checkOutput("repress_after_reset", press, 4'b0010);
        applyStimulus(IDLE, '0, 1'b0, 10);

        // Random phase: slowly changing keys, occasional enable flips and resets.
        for (int n = 0; n < 1200; n++) begin
            logic [NK-1:0] raw;
            logic [NK-1:0] ren;
            logic          rst;
            raw = keys_raw;
            ren = repeat_en;
            rst = 1'b0;
            if ($urandom_range(0, 5) == 0) raw[$urandom_range(0, NK-1)] ^= 1'b1;
            if ($urandom_range(0, 24) == 0) ren[$urandom_range(0, NK-1)] ^= 1'b1;
            if ($urandom_range(0, 299) == 0) rst = 1'b1;
            applyStimulus(raw, ren, rst, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
